// File: rtl/map_axi_pkg.sv
// rtl/map_axi_pkg.sv - shared AXI encodings, AR FSM states and size helper for map_axi_rd_mst
package map_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic {
      IDLE,
      ISSUE
   } ar_state_e;

   // AXI arsize encoding: log2 of the bytes per beat
   function automatic logic [2:0] axi_size(input int data_width);
      int         bytes;
      logic [2:0] s;
      bytes = data_width / 8;
      s     = '0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == bytes) s = 3'(i);
      end
      return s;
   endfunction

endpackage

// File: rtl/map_rdata_fifo.sv
// rtl/map_rdata_fifo.sv - synchronous first-word-fall-through FIFO for returned R beats
module map_rdata_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 128
) (
   input  logic                     clk_300m,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   // Pointer/count update; a write into a full FIFO is allowed when a pop frees the slot
   always_comb begin
      do_rd    = rd_en && (count_q != '0);
      do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers
   always_ff @(posedge clk_300m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because the count gates visibility
   always_ff @(posedge clk_300m) begin
      if (do_wr) mem_q[wr_ptr_q] <= din;
   end

   // Head word is forced to zero while empty so stale data never leaks out
   assign dout  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

endmodule

// File: rtl/map_axi_rd_mst.sv
// rtl/map_axi_rd_mst.sv - AXI4 read master feeding map_ctrl; optional MAP_AXI_RESP_CHK_EN response checking
module map_axi_rd_mst
   import map_axi_pkg::*;
#(
   parameter int AXIADDR_WIDTH   = 32,
   parameter int AXIDATA_WIDTH   = 128,
   parameter int BURSTBIT        = 8,
   parameter int OUTSTANDING_NUM = 4,
   parameter int MAX_BEATS       = 16,
   parameter int FIFO_DEPTH      = 64
) (
   input  logic                      clk_300m,
   input  logic                      rst_n,
   input  logic                      frame_pos,
   input  logic                      map_req,
   input  logic [AXIADDR_WIDTH-1:0]  map_addr,
   input  logic [BURSTBIT-1:0]       map_burst,
   output logic                      map_ready,
   output logic                      mapbuffer_empty,
   input  logic                      map_rd,
   output logic [AXIDATA_WIDTH-1:0]  map_data,
   output logic [AXIADDR_WIDTH-1:0]  m_axi_araddr,
   output logic [BURSTBIT-1:0]       m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXIDATA_WIDTH-1:0]  m_axi_rdata,
   input  logic                      m_axi_rvalid,
   input  logic                      m_axi_rlast,
   input  logic [1:0]                m_axi_rresp,
   output logic                      m_axi_rready,
   output logic [31:0]               frame_beat_cnt,
   output logic                      rd_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = $clog2(OUTSTANDING_NUM + 1);

   ar_state_e                 state_q, state_d;
   logic [AXIADDR_WIDTH-1:0]  araddr_q, araddr_d;
   logic [BURSTBIT-1:0]       arlen_q, arlen_d;
   logic                      map_ready_q, map_ready_d;
   logic                      rready_q, rready_d;
   logic [OW-1:0]             out_cnt_q, out_cnt_d;
   logic [CW-1:0]             credit_q, credit_d;
   logic [31:0]               frame_beat_cnt_q, frame_beat_cnt_d;
   logic [CW-1:0]             burst_beats;

   logic                      accept, beat, rlast_hs, pop, fifo_empty;
   logic                      unused_fifo_full;
   logic [CW-1:0]             unused_fifo_count;

   assign accept   = map_req && map_ready_q;
   assign beat     = m_axi_rvalid && rready_q;
   assign rlast_hs = beat && m_axi_rlast;
   assign pop      = map_rd && !fifo_empty;

   // AR channel FSM: load the burst on accept, hold it until the slave takes it
   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      arlen_d  = arlen_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = ISSUE;
               araddr_d = map_addr;
               arlen_d  = map_burst;
            end
         end
         ISSUE: begin
            if (m_axi_arready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Credit, outstanding and beat counters plus the registered request-ready
   always_comb begin
      burst_beats = CW'({1'b0, map_burst}) + CW'(1);
      credit_d    = credit_q;
      if (accept) credit_d = credit_d - burst_beats;
      if (pop)    credit_d = credit_d + CW'(1);

      out_cnt_d = out_cnt_q;
      if (accept && !rlast_hs)
         out_cnt_d = out_cnt_q + OW'(1);
      else if (!accept && rlast_hs && (out_cnt_q != '0))
         out_cnt_d = out_cnt_q - OW'(1);

      // Excluding this cycle's accept keeps map_ready low while the new AR is loading
      map_ready_d = !accept && (state_q == IDLE) &&
                    (out_cnt_q < OW'(OUTSTANDING_NUM)) &&
                    (credit_q >= CW'(MAX_BEATS));

      // Every beat already has FIFO space reserved, so R is always accepted
      rready_d = 1'b1;

      frame_beat_cnt_d = frame_pos ? 32'd0 : frame_beat_cnt_q;
      if (beat) frame_beat_cnt_d = frame_beat_cnt_d + 32'd1;
   end

   // Main state registers
   always_ff @(posedge clk_300m or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         araddr_q         <= '0;
         arlen_q          <= '0;
         map_ready_q      <= 1'b0;
         rready_q         <= 1'b0;
         out_cnt_q        <= '0;
         credit_q         <= CW'(FIFO_DEPTH);
         frame_beat_cnt_q <= '0;
      end else begin
         state_q          <= state_d;
         araddr_q         <= araddr_d;
         arlen_q          <= arlen_d;
         map_ready_q      <= map_ready_d;
         rready_q         <= rready_d;
         out_cnt_q        <= out_cnt_d;
         credit_q         <= credit_d;
         frame_beat_cnt_q <= frame_beat_cnt_d;
      end
   end

   map_rdata_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (AXIDATA_WIDTH)
   ) u_fifo (
      .clk_300m (clk_300m),
      .rst_n    (rst_n),
      .wr_en    (beat),
      .din      (m_axi_rdata),
      .rd_en    (map_rd),
      .dout     (map_data),
      .empty    (fifo_empty),
      .full     (unused_fifo_full),
      .count    (unused_fifo_count)
   );

`ifdef MAP_AXI_RESP_CHK_EN
   localparam int QW = (OUTSTANDING_NUM > 1) ? $clog2(OUTSTANDING_NUM) : 1;

   logic [BURSTBIT-1:0] len_q [OUTSTANDING_NUM];
   logic [QW-1:0]       lq_wr_q, lq_wr_d;
   logic [QW-1:0]       lq_rd_q, lq_rd_d;
   logic [BURSTBIT-1:0] rbeat_q, rbeat_d;
   logic                rd_err_q, rd_err_d;
   logic                err_now;

   function automatic logic [QW-1:0] lq_next(input logic [QW-1:0] p);
      return (p == QW'(OUTSTANDING_NUM - 1)) ? '0 : p + QW'(1);
   endfunction

   // Response and burst-length checking; the queue occupancy equals out_cnt
   always_comb begin
      lq_wr_d = lq_wr_q;
      lq_rd_d = lq_rd_q;
      rbeat_d = rbeat_q;
      err_now = 1'b0;
      if (accept) lq_wr_d = lq_next(lq_wr_q);
      if (beat) begin
         if (m_axi_rresp != AXI_RESP_OKAY) err_now = 1'b1;
         if (out_cnt_q == '0)
            err_now = 1'b1;
         else if (m_axi_rlast != (rbeat_q == len_q[lq_rd_q]))
            err_now = 1'b1;
         if (m_axi_rlast) begin
            rbeat_d = '0;
            if (out_cnt_q != '0) lq_rd_d = lq_next(lq_rd_q);
         end else begin
            rbeat_d = rbeat_q + BURSTBIT'(1);
         end
      end
      rd_err_d = (frame_pos ? 1'b0 : rd_err_q) | err_now;
   end

   // Checker state registers
   always_ff @(posedge clk_300m or negedge rst_n) begin
      if (!rst_n) begin
         lq_wr_q  <= '0;
         lq_rd_q  <= '0;
         rbeat_q  <= '0;
         rd_err_q <= 1'b0;
      end else begin
         lq_wr_q  <= lq_wr_d;
         lq_rd_q  <= lq_rd_d;
         rbeat_q  <= rbeat_d;
         rd_err_q <= rd_err_d;
      end
   end

   // Expected burst lengths, captured in request order
   always_ff @(posedge clk_300m) begin
      if (accept) len_q[lq_wr_q] <= map_burst;
   end

   assign rd_err = rd_err_q;
`else
   logic unused_rresp;
   assign unused_rresp = ^m_axi_rresp;
   assign rd_err       = 1'b0;
`endif

   assign map_ready       = map_ready_q;
   assign mapbuffer_empty = fifo_empty;
   assign m_axi_araddr    = araddr_q;
   assign m_axi_arlen     = arlen_q;
   assign m_axi_arsize    = axi_size(AXIDATA_WIDTH);
   assign m_axi_arburst   = AXI_BURST_INCR;
   assign m_axi_arvalid   = (state_q == ISSUE);
   assign m_axi_rready    = rready_q;
   assign frame_beat_cnt  = frame_beat_cnt_q;

endmodule
